// File: rtl/cpu_sequencer_pkg.sv
// Shared instruction format, opcode/func encodings and widths for the sequencer and program ROM.
package cpu_sequencer_pkg;

  localparam int unsigned INSTR_W = 35;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned FLAG_W  = 8;
  localparam int unsigned OPC_W   = 4;
  localparam int unsigned FUNC_W  = 3;
  localparam int unsigned REG_W   = 10;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP = 4'd0,
    OP_JMP = 4'd1,
    OP_ATC = 4'd2,
    OP_MOV = 4'd3,
    OP_ACC = 4'd4
  } opcode_e;

  typedef enum logic [FUNC_W-1:0] {
    FUNC_UNC = 3'd0
  } func_e;

  // Field order fixes bit positions: opcode[34:31] func[30:28] src[27:18] dst[17:8] target[7:0]
  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [FUNC_W-1:0] func;
    logic [REG_W-1:0]  src;
    logic [REG_W-1:0]  dst;
    logic [ADDR_W-1:0] target;
  } instr_t;

  function automatic logic is_exec_op(input logic [OPC_W-1:0] op);
    return (op == OP_MOV) || (op == OP_ACC);
  endfunction

endpackage

// File: rtl/branch_resolve.sv
// Combinational branch decision for JMP/ATC held in ir; every other opcode falls through to pc+1.
module branch_resolve
  import cpu_sequencer_pkg::*;
(
  input  logic [INSTR_W-1:0] ir,
  input  logic [ADDR_W-1:0]  pc,
  input  logic [FLAG_W-1:0]  flags,
  input  logic               cmp_true,
  output logic               taken,
  output logic [ADDR_W-1:0]  next_pc
);

  instr_t instr;
  logic [2*REG_W-1:0] unused_operands;

  assign instr           = instr_t'(ir);
  assign unused_operands = {instr.src, instr.dst};

  always_comb begin
    taken = 1'b0;
    case (instr.opcode)
      OP_JMP:  taken = (instr.func == FUNC_UNC) || cmp_true;
      OP_ATC:  taken = flags[instr.func];
      default: taken = 1'b0;
    endcase
    next_pc = taken ? instr.target : pc + ADDR_W'(1);
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute sequencer: walks the program ROM, resolves branches and hands MOV/ACC to the datapath.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic [FLAG_W-1:0]  flags,
  input  logic               cmp_true,
  output logic [INSTR_W-1:0] ir,
  output logic               exec_valid,
  input  logic               exec_ready,
  output logic [ADDR_W-1:0]  pc,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2
  } state_e;

  state_e             st;
  logic [ADDR_W-1:0]  br_next_pc;
  logic               br_taken_unused;

  // pc is a register, so the ROM address never moves outside a pc update
  assign rom_addr = pc;
  assign state    = st;

  branch_resolve u_branch_resolve (
    .ir       (ir),
    .pc       (pc),
    .flags    (flags),
    .cmp_true (cmp_true),
    .taken    (br_taken_unused),
    .next_pc  (br_next_pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st         <= S_FETCH;
      pc         <= '0;
      ir         <= '0;
      exec_valid <= 1'b0;
    end else begin
      case (st)
        S_FETCH: begin
          ir <= rom_data;
          st <= S_DECODE;
        end
        S_DECODE: begin
          if (is_exec_op(ir[INSTR_W-1 -: OPC_W])) begin
            st         <= S_EXEC;
            exec_valid <= 1'b1;
          end else begin
            pc <= br_next_pc;
            st <= S_FETCH;
          end
        end
        S_EXEC: begin
          if (exec_ready) begin
            pc         <= pc + ADDR_W'(1);
            st         <= S_FETCH;
            exec_valid <= 1'b0;
          end
        end
        default: begin
          st         <= S_FETCH;
          exec_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench: instruction-level timing model compared every cycle plus directed program checks.
module tb_cpu_sequencer;

  logic        clk;
  logic        reset;
  logic [7:0]  rom_addr;
  logic [34:0] rom_data;
  logic [7:0]  flags;
  logic        cmp_true;
  logic [34:0] ir;
  logic        exec_valid;
  logic        exec_ready;
  logic [7:0]  pc;
  logic [1:0]  state;

  logic [34:0] rom [256];
  int checks = 0;
  int errors = 0;
  logic run_cmp = 1'b0;

  // Model: address of the instruction in flight, its latched word, and cycles spent on it so far
  logic [7:0]  m_pc;
  logic [34:0] m_ir;
  int          m_cyc;

  cpu_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .flags      (flags),
    .cmp_true   (cmp_true),
    .ir         (ir),
    .exec_valid (exec_valid),
    .exec_ready (exec_ready),
    .pc         (pc),
    .state      (state)
  );

  assign rom_data = rom[rom_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [34:0] mk(input logic [3:0] op, input logic [2:0] fn,
                                     input logic [9:0] src, input logic [9:0] dst,
                                     input logic [7:0] tgt);
    return {op, fn, src, dst, tgt};
  endfunction

  function automatic logic m_is_exec(input logic [34:0] w);
    logic [3:0] op;
    op = w[34:31];
    return (op == 4'd3) || (op == 4'd4);
  endfunction

  function automatic logic [7:0] m_next(input logic [34:0] w, input logic [7:0] a,
                                        input logic [7:0] f, input logic c);
    logic [3:0] op;
    logic [2:0] fn;
    logic       t;
    op = w[34:31];
    fn = w[30:28];
    t  = ((op == 4'd1) && ((fn == 3'd0) || c)) || ((op == 4'd2) && f[fn]);
    return t ? w[7:0] : a + 8'd1;
  endfunction

  task automatic check(input string name, input logic [34:0] got, input logic [34:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // One step per clock: fetch takes a cycle, branch/NOP retire in decode, MOV/ACC retire on a ready cycle
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc  = 8'd0;
      m_ir  = '0;
      m_cyc = 0;
    end else if (m_cyc == 0) begin
      m_ir  = rom[m_pc];
      m_cyc = 1;
    end else if (m_is_exec(m_ir)) begin
      if (m_cyc >= 2 && exec_ready) begin
        m_pc  = m_pc + 8'd1;
        m_cyc = 0;
      end else if (m_cyc < 1000) begin
        m_cyc++;
      end
    end else begin
      m_pc  = m_next(m_ir, m_pc, flags, cmp_true);
      m_cyc = 0;
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      check("rom_addr", 35'(rom_addr), 35'(m_pc));
      check("pc", 35'(pc), 35'(m_pc));
      check("ir", ir, m_ir);
      check("state", 35'(state), (m_cyc == 0) ? 35'd0 : (m_cyc == 1) ? 35'd1 : 35'd2);
      check("exec_valid", 35'(exec_valid), 35'(m_is_exec(m_ir) && m_cyc >= 2));
    end
  end

  task automatic wait_addr(input logic [7:0] a, input int budget);
    int n = 0;
    while (rom_addr !== a && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_addr", 35'(rom_addr), 35'(a));
  endtask

  task automatic skip(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int cnt;
    logic seen;
    reset      = 1'b1;
    flags      = 8'h00;
    cmp_true   = 1'b0;
    exec_ready = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = '0;
    rom[0]  = mk(4'd0, 3'd0, 10'h155, 10'h0AA, 8'd0);
    rom[3]  = mk(4'd9, 3'd0, 10'h000, 10'h000, 8'd200);
    rom[7]  = mk(4'd2, 3'd3, 10'h000, 10'h000, 8'd12);
    rom[11] = mk(4'd1, 3'd0, 10'h000, 10'h000, 8'd7);
    rom[12] = mk(4'd3, 3'd0, 10'h001, 10'h002, 8'd0);
    rom[13] = mk(4'd1, 3'd1, 10'h000, 10'h000, 8'd67);
    rom[14] = mk(4'd1, 3'd0, 10'h000, 10'h000, 8'd254);
    rom[67] = mk(4'd4, 3'd0, 10'h000, 10'h000, 8'd0);

    #2;
    check("reset_rom_addr", 35'(rom_addr), 35'd0);
    check("reset_exec_valid", 35'(exec_valid), 35'd0);
    check("reset_ir", ir, 35'd0);
    check("reset_state", 35'(state), 35'd0);
    run_cmp = 1'b1;
    skip(2);
    reset = 1'b0;

    skip(1);
    check("first_fetch_addr", 35'(rom_addr), 35'd0);
    check("first_fetch_ir", ir, mk(4'd0, 3'd0, 10'h155, 10'h0AA, 8'd0));
    skip(1);
    check("nop_step_1", 35'(rom_addr), 35'd1);
    skip(2);
    check("nop_step_2", 35'(rom_addr), 35'd2);

    wait_addr(8'd7, 40);
    skip(2);
    check("atc_not_taken", 35'(rom_addr), 35'd8);
    wait_addr(8'd11, 40);
    skip(2);
    check("jmp_unc", 35'(rom_addr), 35'd7);
    flags = 8'h08;
    skip(2);
    check("atc_taken", 35'(rom_addr), 35'd12);

    cnt  = 0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (exec_valid) begin
        seen = 1'b1;
        cnt++;
        check("mov_pc_hold", 35'(pc), 35'd12);
        if (cnt == 4) exec_ready = 1'b1;
      end else if (seen) begin
        break;
      end
    end
    check("mov_valid_cycles", 35'(cnt), 35'd4);
    check("mov_next_addr", 35'(rom_addr), 35'd13);
    exec_ready = 1'b0;
    cmp_true   = 1'b1;

    wait_addr(8'd67, 40);
    skip(2);
    check("acc_in_exec", 35'(exec_valid), 35'd1);
    #2 reset = 1'b1;
    #1;
    check("midexec_valid", 35'(exec_valid), 35'd0);
    check("midexec_rom_addr", 35'(rom_addr), 35'd0);
    check("midexec_ir", ir, 35'd0);
    @(negedge clk);
    reset      = 1'b0;
    exec_ready = 1'b1;
    cmp_true   = 1'b0;
    skip(1);
    check("resume_addr", 35'(rom_addr), 35'd0);

    wait_addr(8'd12, 60);
    skip(3);
    check("mov_fast_latency", 35'(rom_addr), 35'd13);
    skip(2);
    check("jmp_cond_not_taken", 35'(rom_addr), 35'd14);
    skip(2);
    check("jmp_far", 35'(rom_addr), 35'd254);
    wait_addr(8'd255, 10);
    skip(2);
    check("pc_wrap", 35'(rom_addr), 35'd0);
    skip(4);

    run_cmp = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
